microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Next-state engine for the multicycle MIPS control unit.
- Each cycle it consumes the 2-bit address-control field of the current microinstruction and the IR opcode, and produces the registered 4-bit state that indexes the control ROM.
- Implements sequential increment, two opcode dispatch tables and return-to-fetch.
- Adds stall support, illegal-opcode detection and a retired-instruction counter.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- addrctl  input  2  next-address select: 00 SEQ (state+1), 01 DISP1, 10 DISP2, 11 FETCH (go to state 0).
- opcode  input  6  IR[31:26]; valid from DECODE onward.
- hold  input  1  stall (memory not ready); freezes all registers.
- state  output  4  current control state, registered.
- instr_done  output  1  one-cycle pulse, registered, on the edge that retires an instruction.
- illegal_op  output  1  one-cycle pulse, registered, on an unrecognised opcode.
- retired  output  COUNT_W  count of retired instructions, registered.

Behaviour:
- Reset values: state=0 (FETCH), instr_done=0, illegal_op=0, retired=0.
- Priority order: reset > hold > normal update.
- While hold=1: state and retired are unchanged, instr_done=0 and illegal_op=0 (pulses never stretch).
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, JEX=9.
- SEQ: next = state+1.
  - If state+1 > 9, next = FETCH and illegal_op pulses.
  - That case does not retire an instruction.
- DISP1 table:
  - 0x00 -> RTYPEEX
  - 0x23 lw -> MEMADR
  - 0x2B sw -> MEMADR
  - 0x04 beq -> BEQEX
  - 0x02 j -> JEX
  - any other opcode -> FETCH with illegal_op=1, no retire.
- DISP2 table:
  - 0x23 -> MEMRD
  - 0x2B -> MEMWR
  - any other opcode -> FETCH with illegal_op=1, no retire.
- FETCH (addrctl=11): next = FETCH.
  - If the current state != FETCH: instr_done=1 next cycle and retired += 1.
  - retired wraps modulo 2^COUNT_W with no saturation and no flag.
  - If the current state == FETCH: no retire.
- Latency: one cycle from the addrctl/opcode sample to the new state. Pulses align with the state they accompany.
- Reset mid-instruction: state returns to FETCH on that edge. No instr_done, no illegal_op, and retired clears.
- Opcode is sampled only when addrctl selects DISP1 or DISP2; it is ignored otherwise.
- addrctl is treated as fully defined; no X handling is required.

Decomposition:
- Package microcode_pkg holds:
  - state localparams (FETCH..JEX);
  - opcode constants (OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_J=6'h02);
  - addrctl codes (AC_SEQ, AC_DISP1, AC_DISP2, AC_FETCH).
- One combinational sub-module, dispatch_rom:
  - inputs: opcode, table select;
  - outputs: 4-bit target and a valid bit.
- The registered sequencer, stall logic and counter stay in microsequencer.

Test Plan:
- Reset held 2 cycles, then released with addrctl=00 -> state goes 0,1; retired=0; no pulses.
- lw path: opcode 0x23, addrctl sequence SEQ, DISP1, DISP2, SEQ, FETCH -> states 0,1,2,3,4,0; instr_done pulses once on return to 0; retired=1.
- R-type, beq and j back to back (opcodes 0x00, 0x04, 0x02) -> paths 0-1-6-7-0, 0-1-8-0, 0-1-9-0; retired=3; three instr_done pulses.
- Illegal opcode 0x3F with DISP1 in DECODE -> state 0 next cycle; illegal_op=1 for exactly one cycle; retired unchanged. Repeat with DISP2 from MEMADR using opcode 0x04 -> same result.
- hold=1 for 3 cycles while in MEMRD -> state stays 3, no pulses. Release -> advances to 4. A FETCH edge arriving during hold -> neither retire nor pulse until hold drops.
- COUNT_W=4: retire 16 instructions -> retired wraps 15 -> 0. Reset asserted in RTYPEEX -> state=0 and retired=0 next cycle.

Source files
------------

// File: rtl/microcode_pkg.sv
// Shared constants for the multicycle MIPS microsequencer: control-state
// encodings, IR opcodes recognised by the dispatch tables and address-control codes.
package microcode_pkg;

    // Control states (index into the control ROM)
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] JEX     = 4'd9;

    // Highest legal state; sequencing past it is an error
    localparam logic [3:0] LAST_STATE = JEX;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // Next-address select codes
    localparam logic [1:0] AC_SEQ   = 2'b00;
    localparam logic [1:0] AC_DISP1 = 2'b01;
    localparam logic [1:0] AC_DISP2 = 2'b10;
    localparam logic [1:0] AC_FETCH = 2'b11;

endpackage

// File: rtl/dispatch_rom.sv
// Combinational opcode dispatch tables. sel=0 selects the DECODE table (DISP1),
// sel=1 the memory-address table (DISP2). valid=0 flags an unrecognised opcode.
module dispatch_rom
    import microcode_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       sel,
    output logic [3:0] target,
    output logic       valid
);

    // Table lookup; unmatched opcodes fall through to FETCH with valid low
    always_comb begin
        target = FETCH;
        valid  = 1'b0;
        if (!sel) begin
            case (opcode)
                OP_RTYPE: begin target = RTYPEEX; valid = 1'b1; end
                OP_LW:    begin target = MEMADR;  valid = 1'b1; end
                OP_SW:    begin target = MEMADR;  valid = 1'b1; end
                OP_BEQ:   begin target = BEQEX;   valid = 1'b1; end
                OP_J:     begin target = JEX;     valid = 1'b1; end
                default:  ;
            endcase
        end else begin
            case (opcode)
                OP_LW:    begin target = MEMRD;   valid = 1'b1; end
                OP_SW:    begin target = MEMWR;   valid = 1'b1; end
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Next-state engine for the multicycle MIPS control unit: sequential increment,
// opcode dispatch, return-to-fetch, stall, illegal-opcode pulse and retire counter.
module microsequencer
    import microcode_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         addrctl,
    input  logic [5:0]         opcode,
    input  logic               hold,
    output logic [3:0]         state,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] retired
);

    logic [3:0]         state_d;
    logic               done_d;
    logic               illegal_d;
    logic [COUNT_W-1:0] retired_d;
    logic [3:0]         rom_target;
    logic               rom_valid;
    logic [4:0]         seq_next;

    // Extra bit so state+1 from 15 cannot alias back into the legal range
    assign seq_next = {1'b0, state} + 5'd1;

    dispatch_rom u_dispatch_rom (
        .opcode (opcode),
        .sel    (addrctl == AC_DISP2),
        .target (rom_target),
        .valid  (rom_valid)
    );

    // Next-state, pulse and counter update; hold keeps the defaults (freeze, no pulses)
    always_comb begin
        state_d   = state;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        retired_d = retired;
        if (!hold) begin
            case (addrctl)
                AC_SEQ: begin
                    if (seq_next > {1'b0, LAST_STATE}) begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = seq_next[3:0];
                    end
                end
                AC_DISP1, AC_DISP2: begin
                    if (rom_valid) begin
                        state_d = rom_target;
                    end else begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                end
                AC_FETCH: begin
                    state_d = FETCH;
                    // Returning to FETCH from elsewhere completes an instruction
                    if (state != FETCH) begin
                        done_d    = 1'b1;
                        retired_d = retired + COUNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered state, pulses and counter with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            instr_done <= 1'b0;
            illegal_op <= 1'b0;
            retired    <= '0;
        end else begin
            state      <= state_d;
            instr_done <= done_d;
            illegal_op <= illegal_d;
            retired    <= retired_d;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios plus randomized
// stimulus against a table-driven reference model. Two DUTs share the inputs,
// one with a 32-bit and one with a 4-bit retire counter.
module tb_microsequencer;

    logic        clk = 1'b0;
    logic        reset, hold;
    logic [1:0]  addrctl;
    logic [5:0]  opcode;

    logic [3:0]  state_a, state_b;
    logic        done_a, done_b, ill_a, ill_b;
    logic [31:0] ret_a;
    logic [3:0]  ret_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_state;
    bit          m_done, m_ill;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    microsequencer #(.COUNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .addrctl(addrctl), .opcode(opcode), .hold(hold),
        .state(state_a), .instr_done(done_a), .illegal_op(ill_a), .retired(ret_a)
    );

    microsequencer #(.COUNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .addrctl(addrctl), .opcode(opcode), .hold(hold),
        .state(state_b), .instr_done(done_b), .illegal_op(ill_b), .retired(ret_b)
    );

    // Drive one cycle of inputs, advance the model on the edge, settle #1 after
    task automatic step(input logic r, input logic h, input logic [1:0] ac,
                        input logic [5:0] op);
        int nxt;
        reset = r; hold = h; addrctl = ac; opcode = op;
        @(posedge clk);
        m_done = 0;
        m_ill  = 0;
        if (r) begin
            m_state = 0;
            m_ret   = 0;
        end else if (!h) begin
            nxt = -1;
            if (ac == 2'd0) begin
                nxt = (m_state + 1 <= 9) ? m_state + 1 : -1;
            end else if (ac == 2'd1) begin
                if (op == 6'h00) nxt = 6;
                else if (op == 6'h23 || op == 6'h2B) nxt = 2;
                else if (op == 6'h04) nxt = 8;
                else if (op == 6'h02) nxt = 9;
            end else if (ac == 2'd2) begin
                if (op == 6'h23) nxt = 3;
                else if (op == 6'h2B) nxt = 5;
            end else begin
                nxt = 0;
                if (m_state != 0) begin
                    m_done = 1;
                    m_ret  = m_ret + 1;
                end
            end
            if (nxt < 0) begin
                m_ill   = 1;
                m_state = 0;
            end else begin
                m_state = nxt;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 2'd0, 6'h00);
        step(1, 0, 2'd0, 6'h00);
        n_checks++;
        if (state_a !== 4'd0 || done_a !== 1'b0 || ill_a !== 1'b0 || ret_a !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_values: state=%0d done=%b ill=%b ret=%0d required 0/0/0/0",
                     state_a, done_a, ill_a, ret_a);
        end
        n_checks++;
        if (ret_b !== 4'd0 || state_b !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_values_w4: state=%0d ret=%0d required 0/0", state_b, ret_b);
        end
        step(0, 0, 2'd0, 6'h00);
        n_checks++;
        if (state_a !== 4'd1 || done_a !== 1'b0 || ill_a !== 1'b0 || ret_a !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_release: state=%0d done=%b ill=%b ret=%0d required 1/0/0/0",
                     state_a, done_a, ill_a, ret_a);
        end
    endtask

    task automatic test_lw();
        logic [1:0] acs [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
        int         exps[5] = '{1, 2, 3, 4, 0};
        int         dones = 0;
        step(1, 0, 2'd0, 6'h00);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, acs[i], 6'h23);
            dones += int'(done_a);
            n_checks++;
            if (state_a !== 4'(exps[i]) || ill_a !== 1'b0) begin
                n_errors++;
                $display("FAIL lw_path[%0d]: state=%0d ill=%b required %0d/0",
                         i, state_a, ill_a, exps[i]);
            end
        end
        n_checks++;
        if (done_a !== 1'b1 || dones != 1 || ret_a !== 32'd1) begin
            n_errors++;
            $display("FAIL lw_retire: done=%b pulses=%0d ret=%0d required 1/1/1",
                     done_a, dones, ret_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] acs [10] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 6'h04, 6'h04,
                                 6'h02, 6'h02, 6'h02};
        int         exps[10] = '{1, 6, 7, 0, 1, 8, 0, 1, 9, 0};
        int         dones = 0;
        step(1, 0, 2'd0, 6'h00);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, acs[i], ops[i]);
            dones += int'(done_a);
            n_checks++;
            if (state_a !== 4'(exps[i]) || done_a !== (exps[i] == 0)) begin
                n_errors++;
                $display("FAIL b2b_path[%0d]: state=%0d done=%b required %0d/%b",
                         i, state_a, done_a, exps[i], exps[i] == 0);
            end
        end
        n_checks++;
        if (ret_a !== 32'd3 || dones != 3) begin
            n_errors++;
            $display("FAIL b2b_retired: ret=%0d pulses=%0d required 3/3", ret_a, dones);
        end
    endtask

    task automatic test_illegal();
        step(1, 0, 2'd0, 6'h00);
        step(0, 0, 2'd0, 6'h00);
        step(0, 0, 2'd1, 6'h3F);
        n_checks++;
        if (state_a !== 4'd0 || ill_a !== 1'b1 || done_a !== 1'b0 || ret_a !== 32'd0) begin
            n_errors++;
            $display("FAIL illegal_disp1: state=%0d ill=%b done=%b ret=%0d required 0/1/0/0",
                     state_a, ill_a, done_a, ret_a);
        end
        step(0, 0, 2'd0, 6'h00);
        n_checks++;
        if (ill_a !== 1'b0 || state_a !== 4'd1) begin
            n_errors++;
            $display("FAIL illegal_one_cycle: ill=%b state=%0d required 0/1", ill_a, state_a);
        end
        step(0, 0, 2'd1, 6'h23);
        step(0, 0, 2'd2, 6'h04);
        n_checks++;
        if (state_a !== 4'd0 || ill_a !== 1'b1 || ret_a !== 32'd0) begin
            n_errors++;
            $display("FAIL illegal_disp2: state=%0d ill=%b ret=%0d required 0/1/0",
                     state_a, ill_a, ret_a);
        end
        step(0, 0, 2'd3, 6'h00);
        n_checks++;
        if (ill_a !== 1'b0 || done_a !== 1'b0 || ret_a !== 32'd0) begin
            n_errors++;
            $display("FAIL illegal_fetch_idle: ill=%b done=%b ret=%0d required 0/0/0",
                     ill_a, done_a, ret_a);
        end
    endtask

    task automatic test_hold();
        step(1, 0, 2'd0, 6'h00);
        step(0, 0, 2'd0, 6'h23);
        step(0, 0, 2'd1, 6'h23);
        step(0, 0, 2'd2, 6'h23);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'd0, 6'h23);
            n_checks++;
            if (state_a !== 4'd3 || done_a !== 1'b0 || ill_a !== 1'b0) begin
                n_errors++;
                $display("FAIL hold_memrd[%0d]: state=%0d done=%b ill=%b required 3/0/0",
                         i, state_a, done_a, ill_a);
            end
        end
        step(0, 0, 2'd0, 6'h23);
        n_checks++;
        if (state_a !== 4'd4) begin
            n_errors++;
            $display("FAIL hold_release: state=%0d required 4", state_a);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 2'd3, 6'h00);
            n_checks++;
            if (state_a !== 4'd4 || done_a !== 1'b0 || ret_a !== 32'd0) begin
                n_errors++;
                $display("FAIL hold_fetch[%0d]: state=%0d done=%b ret=%0d required 4/0/0",
                         i, state_a, done_a, ret_a);
            end
        end
        step(0, 0, 2'd3, 6'h00);
        n_checks++;
        if (state_a !== 4'd0 || done_a !== 1'b1 || ret_a !== 32'd1) begin
            n_errors++;
            $display("FAIL hold_fetch_release: state=%0d done=%b ret=%0d required 0/1/1",
                     state_a, done_a, ret_a);
        end
    endtask

    task automatic test_wrap_and_reset();
        step(1, 0, 2'd0, 6'h00);
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 2'd0, 6'h00);
            step(0, 0, 2'd3, 6'h00);
            if (i >= 15) begin
                n_checks++;
                if (ret_b !== 4'(i) || ret_a !== 32'(i)) begin
                    n_errors++;
                    $display("FAIL wrap[%0d]: ret4=%0d ret32=%0d required %0d/%0d",
                             i, ret_b, ret_a, i % 16, i);
                end
            end
        end
        step(0, 0, 2'd0, 6'h00);
        step(0, 0, 2'd1, 6'h00);
        n_checks++;
        if (state_a !== 4'd6) begin
            n_errors++;
            $display("FAIL reach_rtypeex: state=%0d required 6", state_a);
        end
        step(1, 0, 2'd3, 6'h00);
        n_checks++;
        if (state_a !== 4'd0 || ret_a !== 32'd0 || ret_b !== 4'd0 || done_a !== 1'b0
            || ill_a !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: state=%0d ret=%0d ret4=%0d done=%b ill=%b required 0",
                     state_a, ret_a, ret_b, done_a, ill_a);
        end
    endtask

    task automatic test_random();
        logic [5:0] pool[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
        logic [5:0] op;
        step(1, 0, 2'd0, 6'h00);
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pool[$urandom_range(0, 5)];
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                 2'($urandom), op);
            n_checks++;
            if (state_a !== 4'(m_state) || done_a !== m_done || ill_a !== m_ill
                || ret_a !== m_ret || ret_b !== m_ret[3:0] || state_b !== 4'(m_state)
                || done_b !== m_done || ill_b !== m_ill) begin
                n_errors++;
                $display("FAIL random[%0d]: state=%0d done=%b ill=%b ret=%0d ret4=%0d required %0d/%b/%b/%0d/%0d",
                         i, state_a, done_a, ill_a, ret_a, ret_b,
                         m_state, m_done, m_ill, m_ret, m_ret[3:0]);
            end
        end
    endtask

    initial begin
        m_state = 0; m_done = 0; m_ill = 0; m_ret = 0;
        reset = 1'b1; hold = 1'b0; addrctl = 2'd0; opcode = 6'h00;
        test_reset();
        test_lw();
        test_back_to_back();
        test_illegal();
        test_hold();
        test_wrap_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
